lane_bit_serializer: RTL and testbench

Bit-serial transmitter for the two-lane (a/b) byte path. It accepts a parallel word pair per handshake and walks a bit index from 0 to WIDTH-1, emitting one bit of each lane per enabled cycle together with the index. This is the source side of the per-bit capture loop that rebuilds o_a/o_b word-wide. It sits between the lane word producers and the per-bit capture logic in top.

---
 rtl/lane_ser_pkg.sv | 24 ++
 rtl/bit_index_counter.sv | 37 +++
 rtl/lane_bit_serializer.sv | 129 ++++++++++++
 tb/tb_lane_bit_serializer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lane_ser_pkg.sv
// Shared types and helpers for the lane bit serializer and its capture-side peer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package lane_ser_pkg;

    // Default lane word width, shared with the capture side.
    localparam int LANE_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    // Bits needed to hold a bit index in 0..width-1 (ceil(log2(width))).
    function automatic int idx_width(input int width);
        int r;
        r = 0;
        while ((1 << r) < width) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bit_index_counter.sv
// Enable-qualified modulo-MOD counter with synchronous clear and terminal-count flag.
// Latency: count updates on the clock edge after en; tc is combinational from the count.
// Backpressure: none; en=0 holds the count.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset, count to 0
//   clr  - synchronous clear, count to 0
//   en   - advance the count by one (wrapping from MOD-1 back to 0)
//   cnt  - current count, always within 0..MOD-1
//   tc   - high while cnt == MOD-1
module bit_index_counter #(
    parameter int MOD = 8,
    parameter int W   = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    assign tc = (cnt == LAST);

    // Explicit wrap at MOD-1 so non-power-of-2 moduli never reach MOD..2^W-1.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/lane_bit_serializer.sv
// Two-lane bit-serial transmitter: accepts an a/b word pair and emits one bit per lane per enabled cycle.
// Latency: first bit valid the cycle after accept; a word occupies exactly WIDTH enabled cycles.
// Backpressure: o_ready only in IDLE or on an enabled last-bit cycle (zero-bubble back-to-back); i_en=0 stalls with outputs held.
//
// Ports:
//   i_clk, i_rst        - clock and synchronous active-high reset
//   i_en                - shift enable
//   i_valid / o_ready   - word pair handshake for i_a / i_b
//   o_sbit_a / o_sbit_b - current serial bit of each lane
//   o_sidx              - destination bit index of the current bits
//   o_svalid            - serial outputs meaningful (consumer also qualifies on i_en)
//   o_sfirst / o_slast  - first / last bit of the word
//   o_busy              - transfer in progress
module lane_bit_serializer
    import lane_ser_pkg::*;
#(
    parameter int WIDTH     = LANE_W,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_en,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic [WIDTH-1:0]            i_a,
    input  logic [WIDTH-1:0]            i_b,
    output logic                        o_sbit_a,
    output logic                        o_sbit_b,
    output logic [idx_width(WIDTH)-1:0] o_sidx,
    output logic                        o_svalid,
    output logic                        o_sfirst,
    output logic                        o_slast,
    output logic                        o_busy
);

    localparam int IW = idx_width(WIDTH);
    localparam logic [IW-1:0] TOP_IDX = IW'(WIDTH - 1);

    ser_state_t     state_q;
    ser_state_t     state_d;
    logic [IW-1:0]  cnt;
    logic           tc;
    logic [IW-1:0]  sidx;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic           accept;

    assign accept = i_valid && o_ready;

    // Count bits only while shifting; parked at 0 when idle.
    bit_index_counter #(
        .MOD (WIDTH),
        .W   (IW)
    ) u_cnt (
        .clk (i_clk),
        .rst (i_rst),
        .clr (state_q == IDLE),
        .en  ((state_q == SHIFT) && i_en),
        .cnt (cnt),
        .tc  (tc)
    );

    assign sidx = LSB_FIRST ? cnt : (TOP_IDX - cnt);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = SHIFT;
            end
            SHIFT: begin
                // A new accept on the final enabled bit keeps us shifting;
                // the counter wraps to 0 on the same edge.
                if (tc && i_en) state_d = accept ? SHIFT : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: serial outputs derive only from registered state.
    always_comb begin
        o_ready  = 1'b0;
        o_svalid = 1'b0;
        o_busy   = 1'b0;
        o_sidx   = '0;
        o_sbit_a = 1'b0;
        o_sbit_b = 1'b0;
        o_sfirst = 1'b0;
        o_slast  = 1'b0;
        case (state_q)
            IDLE: begin
                o_ready = 1'b1;
            end
            SHIFT: begin
                o_ready  = tc && i_en;
                o_svalid = 1'b1;
                o_busy   = 1'b1;
                o_sidx   = sidx;
                o_sbit_a = sh_a[sidx];
                o_sbit_b = sh_b[sidx];
                o_sfirst = (cnt == '0);
                o_slast  = tc;
            end
            default: ;
        endcase
    end

    // Shadow registers capture the word pair on accept.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sh_a <= '0;
            sh_b <= '0;
        end else if (accept) begin
            sh_a <= i_a;
            sh_b <= i_b;
        end
    end

endmodule

// File: tb/tb_lane_bit_serializer.sv
// Self-checking bench for lane_bit_serializer: three instances (W8 LSB-first, W8 MSB-first, W5 LSB-first).
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_lane_bit_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_s   [3];
    logic       en_s    [3];
    logic       valid_s [3];
    logic [7:0] a_s     [3];
    logic [7:0] b_s     [3];
    logic       ready_s [3];
    logic       sba_s   [3];
    logic       sbb_s   [3];
    logic [2:0] sidx_s  [3];
    logic       sv_s    [3];
    logic       sf_s    [3];
    logic       sl_s    [3];
    logic       busy_s  [3];

    lane_bit_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) u_dut0 (
        .i_clk(clk), .i_rst(rst_s[0]), .i_en(en_s[0]), .i_valid(valid_s[0]), .o_ready(ready_s[0]),
        .i_a(a_s[0]), .i_b(b_s[0]), .o_sbit_a(sba_s[0]), .o_sbit_b(sbb_s[0]), .o_sidx(sidx_s[0]),
        .o_svalid(sv_s[0]), .o_sfirst(sf_s[0]), .o_slast(sl_s[0]), .o_busy(busy_s[0]));

    lane_bit_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) u_dut1 (
        .i_clk(clk), .i_rst(rst_s[1]), .i_en(en_s[1]), .i_valid(valid_s[1]), .o_ready(ready_s[1]),
        .i_a(a_s[1]), .i_b(b_s[1]), .o_sbit_a(sba_s[1]), .o_sbit_b(sbb_s[1]), .o_sidx(sidx_s[1]),
        .o_svalid(sv_s[1]), .o_sfirst(sf_s[1]), .o_slast(sl_s[1]), .o_busy(busy_s[1]));

    lane_bit_serializer #(.WIDTH(5), .LSB_FIRST(1'b1)) u_dut2 (
        .i_clk(clk), .i_rst(rst_s[2]), .i_en(en_s[2]), .i_valid(valid_s[2]), .o_ready(ready_s[2]),
        .i_a(a_s[2][4:0]), .i_b(b_s[2][4:0]), .o_sbit_a(sba_s[2]), .o_sbit_b(sbb_s[2]), .o_sidx(sidx_s[2]),
        .o_svalid(sv_s[2]), .o_sfirst(sf_s[2]), .o_slast(sl_s[2]), .o_busy(busy_s[2]));

    // Reference model: each accepted word becomes a list of expected bit events.
    typedef struct {
        int idx;
        bit ba;
        bit bb;
        bit first;
        bit last;
    } exp_t;

    exp_t q[$];
    int   wd  [3];
    bit   lsb [3];
    int   cur;

    int n_chk = 0;
    int n_fail = 0;

    int         nvalid, run, max_run, max_idx, acc_cnt, cyc;
    logic [7:0] rec_a, rec_b;
    logic       last_acc_slast;
    bit         last_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic void push_word(input logic [7:0] a, input logic [7:0] b);
        for (int k = 0; k < wd[cur]; k++) begin
            exp_t e;
            int   ix;
            ix      = lsb[cur] ? k : wd[cur] - 1 - k;
            e.idx   = ix;
            e.ba    = a[ix];
            e.bb    = b[ix];
            e.first = (k == 0);
            e.last  = (k == wd[cur] - 1);
            q.push_back(e);
        end
    endfunction

    function automatic void clr_stats();
        nvalid = 0; run = 0; max_run = 0; max_idx = 0; acc_cnt = 0; cyc = 0;
        rec_a = '0; rec_b = '0; last_acc_slast = 1'b0; last_acc = 1'b0;
    endfunction

    // Called at a falling edge with inputs already driven: check, update model, advance one cycle.
    task automatic tick();
        int   rem;
        logic exp_rdy;
        logic acc;
        #1;
        rem     = q.size();
        exp_rdy = (rem == 0) || (rem == 1 && en_s[cur]);
        chk("ready",  32'(ready_s[cur]), 32'(exp_rdy));
        chk("svalid", 32'(sv_s[cur]),    32'(rem != 0));
        chk("busy",   32'(busy_s[cur]),  32'(rem != 0));
        if (rem != 0) begin
            chk("sidx",   32'(sidx_s[cur]), 32'(q[0].idx));
            chk("sbit_a", 32'(sba_s[cur]),  32'(q[0].ba));
            chk("sbit_b", 32'(sbb_s[cur]),  32'(q[0].bb));
            chk("sfirst", 32'(sf_s[cur]),   32'(q[0].first));
            chk("slast",  32'(sl_s[cur]),   32'(q[0].last));
        end else begin
            chk("idle_sidx", 32'(sidx_s[cur]), 32'(0));
            chk("idle_bits", 32'({sba_s[cur], sbb_s[cur], sf_s[cur], sl_s[cur]}), 32'(0));
        end
        if (sv_s[cur]) begin
            run++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
        if (sv_s[cur] && en_s[cur]) begin
            nvalid++;
            rec_a[sidx_s[cur]] = sba_s[cur];
            rec_b[sidx_s[cur]] = sbb_s[cur];
            if (int'(sidx_s[cur]) > max_idx) max_idx = int'(sidx_s[cur]);
        end
        acc = valid_s[cur] && exp_rdy && !rst_s[cur];
        if (acc) begin
            acc_cnt++;
            last_acc_slast = sl_s[cur];
        end
        last_acc = acc;
        if (rst_s[cur]) begin
            q.delete();
        end else begin
            if (rem != 0 && en_s[cur]) void'(q.pop_front());
            if (acc) push_word(a_s[cur], b_s[cur]);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain();
        for (int k = 0; k < 64 && q.size() != 0; k++) tick();
        chk("drain_timeout", 32'(q.size()), 32'(0));
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b);
        a_s[cur] = a; b_s[cur] = b; valid_s[cur] = 1'b1;
        tick();
        valid_s[cur] = 1'b0;
    endtask

    initial begin
        wd  = '{8, 8, 5};
        lsb = '{1'b1, 1'b0, 1'b1};
        for (int d = 0; d < 3; d++) begin
            rst_s[d] = 1'b1; en_s[d] = 1'b1; valid_s[d] = 1'b0; a_s[d] = '0; b_s[d] = '0;
        end
        cur = 0;
        clr_stats();
        @(negedge clk);
        tick();
        for (int d = 0; d < 3; d++) rst_s[d] = 1'b0;
        tick();

        // 1: single word, LSB first
        clr_stats();
        send(8'hA5, 8'h3C);
        drain();
        chk("t1_cycles", 32'(cyc), 32'(9));
        chk("t1_nvalid", 32'(nvalid), 32'(8));
        chk("t1_rec_a", 32'(rec_a), 32'(8'hA5));
        chk("t1_rec_b", 32'(rec_b), 32'(8'h3C));
        tick();

        // 2: back-to-back with valid held high
        clr_stats();
        b_s[0] = 8'($urandom);
        a_s[0] = 8'h01; valid_s[0] = 1'b1;
        tick();
        a_s[0] = 8'h80;
        for (int k = 0; k < 20 && acc_cnt < 2; k++) tick();
        valid_s[0] = 1'b0;
        drain();
        chk("t2_accepts", 32'(acc_cnt), 32'(2));
        chk("t2_acc_on_slast", 32'(last_acc_slast), 32'(1));
        chk("t2_run", 32'(max_run), 32'(16));
        chk("t2_nvalid", 32'(nvalid), 32'(16));
        chk("t2_rec_a", 32'(rec_a), 32'(8'h80));

        // 3: stall three cycles at index 4
        clr_stats();
        send(8'h6D, 8'($urandom));
        repeat (4) tick();
        en_s[0] = 1'b0;
        repeat (3) begin
            tick();
            chk("t3_stall_idx", 32'(sidx_s[0]), 32'(4));
            chk("t3_stall_rdy", 32'(ready_s[0]), 32'(0));
            chk("t3_stall_sv",  32'(sv_s[0]), 32'(1));
        end
        en_s[0] = 1'b1;
        drain();
        chk("t3_cycles", 32'(cyc), 32'(12));
        chk("t3_rec_a", 32'(rec_a), 32'(8'h6D));

        // 4: MSB first
        cur = 1;
        clr_stats();
        send(8'hF0, 8'h5A);
        drain();
        chk("t4_rec_a", 32'(rec_a), 32'(8'hF0));
        chk("t4_rec_b", 32'(rec_b), 32'(8'h5A));
        chk("t4_nvalid", 32'(nvalid), 32'(8));

        // 5: reset mid-transfer at index 3
        cur = 0;
        clr_stats();
        send(8'h96, 8'h69);
        repeat (3) tick();
        chk("t5_pre_rst_idx", 32'(sidx_s[0]), 32'(3));
        rst_s[0] = 1'b1;
        tick();
        rst_s[0] = 1'b0;
        chk("t5_post_sv", 32'(sv_s[0]), 32'(0));
        chk("t5_post_busy", 32'(busy_s[0]), 32'(0));
        chk("t5_post_rdy", 32'(ready_s[0]), 32'(1));
        clr_stats();
        send(8'hFF, 8'h00);
        drain();
        chk("t5_rec_a", 32'(rec_a), 32'(8'hFF));
        chk("t5_rec_b", 32'(rec_b), 32'(8'h00));
        chk("t5_nvalid", 32'(nvalid), 32'(8));

        // 6: WIDTH=5 with enable toggling
        cur = 2;
        clr_stats();
        send(8'h1B, 8'h0E);
        for (int k = 0; k < 40 && q.size() != 0; k++) begin
            en_s[2] = (k % 2 == 0);
            tick();
        end
        en_s[2] = 1'b1;
        chk("t6_nvalid", 32'(nvalid), 32'(5));
        chk("t6_max_idx", 32'(max_idx), 32'(4));
        chk("t6_rec_a", 32'(rec_a[4:0]), 32'(5'h1B));
        chk("t6_rec_b", 32'(rec_b[4:0]), 32'(5'h0E));
        tick();

        // Random traffic on every instance
        for (int d = 0; d < 3; d++) begin
            cur = d;
            clr_stats();
            for (int i = 0; i < 300; i++) begin
                if (!(valid_s[d] && !last_acc && !rst_s[d])) begin
                    valid_s[d] = ($urandom_range(0, 2) != 0);
                    a_s[d]     = 8'($urandom);
                    b_s[d]     = 8'($urandom);
                end
                en_s[d]  = ($urandom_range(0, 3) != 0);
                rst_s[d] = ($urandom_range(0, 99) == 0);
                tick();
            end
            valid_s[d] = 1'b0; rst_s[d] = 1'b0; en_s[d] = 1'b1;
            drain();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
